// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter: core-priority access to a single-ported synchronous memory,
// with a starvation guard for the DMA/debug requester and 1-cycle read-response routing.
module dmem_port_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                core_req,
  input  logic                core_we,
  input  logic [ADDR_W-1:0]   core_addr,
  input  logic [DATA_W-1:0]   core_wdata,
  input  logic [DATA_W/8-1:0] core_be,
  output logic                core_gnt,
  output logic                core_stall,
  output logic                core_rvalid,
  output logic [DATA_W-1:0]   core_rdata,
  input  logic                dma_req,
  input  logic                dma_we,
  input  logic [ADDR_W-1:0]   dma_addr,
  input  logic [DATA_W-1:0]   dma_wdata,
  input  logic [DATA_W/8-1:0] dma_be,
  output logic                dma_gnt,
  output logic                dma_rvalid,
  output logic [DATA_W-1:0]   dma_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    RSP_NONE,
    RSP_CORE,
    RSP_DMA
  } rsp_state_t;

  rsp_state_t       rsp_state, rsp_state_nxt;
  logic [CNT_W-1:0] starve_cnt, starve_cnt_nxt;
  logic             dma_win;

  // DMA wins when alone, or when it has lost STARVE_MAX arbitrations in a row.
  always_comb begin
    dma_win    = dma_req & (~core_req | (starve_cnt == STARVE_LIM));
    dma_gnt    = dma_win;
    core_gnt   = core_req & ~dma_win;
    core_stall = core_req & ~core_gnt;
  end

  always_comb begin
    mem_en    = core_gnt | dma_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if (dma_gnt) begin
      mem_we    = dma_we;
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
      mem_be    = dma_be;
    end else if (core_gnt) begin
      mem_we    = core_we;
      mem_addr  = core_addr;
      mem_wdata = core_wdata;
      mem_be    = core_be;
    end
  end

  always_comb begin
    starve_cnt_nxt = starve_cnt;
    if (!dma_req || dma_gnt) begin
      starve_cnt_nxt = '0;
    end else if (starve_cnt != STARVE_LIM) begin
      starve_cnt_nxt = starve_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    rsp_state_nxt = RSP_NONE;
    if (core_gnt && !core_we) begin
      rsp_state_nxt = RSP_CORE;
    end else if (dma_gnt && !dma_we) begin
      rsp_state_nxt = RSP_DMA;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_state  <= RSP_NONE;
      starve_cnt <= '0;
    end else begin
      rsp_state  <= rsp_state_nxt;
      starve_cnt <= starve_cnt_nxt;
    end
  end

  // Read data arrives one cycle after the grant; only the owner sees it.
  always_comb begin
    core_rvalid = (rsp_state == RSP_CORE);
    dma_rvalid  = (rsp_state == RSP_DMA);
    core_rdata  = core_rvalid ? mem_rdata : '0;
    dma_rdata   = dma_rvalid  ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: directed scenarios plus randomized traffic
// against a transaction-level reference model and a behavioural memory.
module tb_dmem_port_arbiter;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned STARVE_MAX = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        core_req, core_we, dma_req, dma_we;
  logic [31:0] core_addr, core_wdata, dma_addr, dma_wdata;
  logic [3:0]  core_be, dma_be;
  logic        core_gnt, core_stall, core_rvalid, dma_gnt, dma_rvalid;
  logic [31:0] core_rdata, dma_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        mem_init;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dmem_port_arbiter #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_be(core_be),
    .core_gnt(core_gnt), .core_stall(core_stall),
    .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_be(dma_be),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] init_val(int unsigned i);
    if (i == 4) return 32'hDEADBEEF;
    return 32'hA5000000 ^ (i * 32'h00010203);
  endfunction

  // Behavioural synchronous single-port memory (64 words, address bits [7:2]).
  logic [31:0] tb_mem [64];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) tb_mem[i] <= init_val(i);
    end else if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) tb_mem[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= tb_mem[mem_addr[7:2]];
      end
    end
  end

  // Reference model: winner 0=none 1=core 2=dma; pending response owner likewise.
  logic [31:0] ref_mem [64];
  int          ref_starve, ref_rsp, ref_win;
  logic [31:0] ref_rdata;
  logic        exp_core_gnt, exp_dma_gnt, exp_stall, exp_mem_en, exp_mem_we;
  logic [31:0] exp_mem_addr, exp_mem_wdata, exp_core_rdata, exp_dma_rdata;
  logic [3:0]  exp_mem_be;
  logic        exp_core_rvalid, exp_dma_rvalid;

  task automatic ref_eval();
    if (core_req && dma_req) ref_win = (ref_starve >= int'(STARVE_MAX)) ? 2 : 1;
    else if (core_req)       ref_win = 1;
    else if (dma_req)        ref_win = 2;
    else                     ref_win = 0;
    exp_core_gnt  = (ref_win == 1);
    exp_dma_gnt   = (ref_win == 2);
    exp_stall     = core_req && (ref_win != 1);
    exp_mem_en    = (ref_win != 0);
    exp_mem_we    = (ref_win == 1) ? core_we    : (ref_win == 2) ? dma_we    : 1'b0;
    exp_mem_addr  = (ref_win == 1) ? core_addr  : (ref_win == 2) ? dma_addr  : 32'h0;
    exp_mem_wdata = (ref_win == 1) ? core_wdata : (ref_win == 2) ? dma_wdata : 32'h0;
    exp_mem_be    = (ref_win == 1) ? core_be    : (ref_win == 2) ? dma_be    : 4'h0;
    exp_core_rvalid = (ref_rsp == 1);
    exp_dma_rvalid  = (ref_rsp == 2);
    exp_core_rdata  = (ref_rsp == 1) ? ref_rdata : 32'h0;
    exp_dma_rdata   = (ref_rsp == 2) ? ref_rdata : 32'h0;
  endtask

  task automatic ref_advance();
    ref_rsp = 0;
    if (ref_win != 0) begin
      if (exp_mem_we) begin
        for (int b = 0; b < 4; b++)
          if (exp_mem_be[b]) ref_mem[exp_mem_addr[7:2]][8*b +: 8] = exp_mem_wdata[8*b +: 8];
      end else begin
        ref_rsp   = ref_win;
        ref_rdata = ref_mem[exp_mem_addr[7:2]];
      end
    end
    if (dma_req && ref_win != 2) ref_starve = (ref_starve < int'(STARVE_MAX)) ? ref_starve + 1 : ref_starve;
    else ref_starve = 0;
  endtask

  task automatic settle();
    @(negedge clk);
    ref_eval();
  endtask

  task automatic advance();
    ref_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0; core_be = '0;
    dma_req  = 0; dma_we  = 0; dma_addr  = '0; dma_wdata  = '0; dma_be  = '0;
  endtask

  task automatic idle_cycle();
    idle_inputs();
    settle();
    advance();
  endtask

  task automatic test_reset();
    core_req = 1; core_we = 0; core_addr = 32'h10;
    dma_req  = 1; dma_we  = 0; dma_addr  = 32'h24;
    for (int k = 0; k < 3; k++) begin
      settle();
      vectors++;
      if ({core_gnt, dma_gnt} !== 2'b10) begin
        miscompares++;
        $display("FAIL reset_pre_gnt[%0d]: got %b expected 10", k, {core_gnt, dma_gnt});
      end
      advance();
    end
    rst_n = 0;
    idle_inputs();
    ref_rsp = 0; ref_starve = 0;
    #1;
    vectors++;
    if ({core_rvalid, dma_rvalid, core_rdata, dma_rdata} !== 66'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: got rv=%b%b crd=%h drd=%h expected all zero",
               core_rvalid, dma_rvalid, core_rdata, dma_rdata);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    ref_eval();
    vectors++;
    if ({mem_en, core_rvalid, dma_rvalid} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_idle: got en/crv/drv=%b expected 000", {mem_en, core_rvalid, dma_rvalid});
    end
    advance();
    core_req = 1; core_addr = 32'h40; dma_req = 1; dma_addr = 32'h44;
    settle();
    vectors++;
    if ({core_gnt, dma_gnt} !== 2'b10) begin
      miscompares++;
      $display("FAIL reset_starve_cleared: got %b expected 10", {core_gnt, dma_gnt});
    end
    advance();
    idle_cycle();
  endtask

  task automatic test_core_load();
    idle_cycle();
    core_req = 1; core_we = 0; core_addr = 32'h10; core_be = 4'hF;
    settle();
    vectors++;
    if ({core_gnt, mem_en, mem_we, mem_addr} !== {3'b110, 32'h10}) begin
      miscompares++;
      $display("FAIL core_load_grant: got gnt/en/we=%b addr=%h expected 110 addr=00000010",
               {core_gnt, mem_en, mem_we}, mem_addr);
    end
    advance();
    idle_inputs();
    settle();
    vectors++;
    if ({core_rvalid, core_rdata, dma_rvalid} !== {1'b1, 32'hDEADBEEF, 1'b0}) begin
      miscompares++;
      $display("FAIL core_load_rsp: got crv=%b crd=%h drv=%b expected 1 deadbeef 0",
               core_rvalid, core_rdata, dma_rvalid);
    end
    advance();
  endtask

  task automatic test_dma_write();
    idle_cycle();
    dma_req = 1; dma_we = 1; dma_addr = 32'h20; dma_wdata = 32'h12345678; dma_be = 4'b0011;
    settle();
    vectors++;
    if ({dma_gnt, core_gnt, mem_we, mem_be, mem_addr, mem_wdata} !==
        {3'b101, 4'b0011, 32'h20, 32'h12345678}) begin
      miscompares++;
      $display("FAIL dma_write_grant: got dg/cg/we=%b be=%b addr=%h wd=%h expected 101 0011 00000020 12345678",
               {dma_gnt, core_gnt, mem_we}, mem_be, mem_addr, mem_wdata);
    end
    advance();
    idle_inputs();
    settle();
    vectors++;
    if ({core_rvalid, dma_rvalid} !== 2'b00) begin
      miscompares++;
      $display("FAIL dma_write_no_rvalid: got %b expected 00", {core_rvalid, dma_rvalid});
    end
    advance();
  endtask

  task automatic test_starvation();
    idle_cycle();
    core_req = 1; core_we = 0; core_addr = 32'h40;
    dma_req  = 1; dma_we  = 0; dma_addr  = 32'h44;
    for (int k = 0; k < 12; k++) begin
      logic cw;
      cw = (k % 4) != 3;
      settle();
      vectors++;
      if ({core_gnt, dma_gnt, core_stall} !== {cw, !cw, !cw}) begin
        miscompares++;
        $display("FAIL starve_pattern[%0d]: got cg/dg/stall=%b expected %b",
                 k, {core_gnt, dma_gnt, core_stall}, {cw, !cw, !cw});
      end
      advance();
    end
    idle_cycle();
  endtask

  task automatic test_back_to_back();
    idle_cycle();
    for (int k = 0; k < 8; k++) begin
      logic [1:0] gexp, rexp;
      idle_inputs();
      if (k % 2 == 0) begin core_req = 1; core_addr = 32'(8 * k + 4); end
      else            begin dma_req  = 1; dma_addr  = 32'(8 * k + 4); end
      gexp = (k % 2 == 0) ? 2'b10 : 2'b01;
      rexp = (k == 0) ? 2'b00 : (k % 2 == 1) ? 2'b10 : 2'b01;
      settle();
      vectors++;
      if ({core_gnt, dma_gnt, core_rvalid, dma_rvalid, core_rdata, dma_rdata} !==
          {gexp, rexp, exp_core_rdata, exp_dma_rdata}) begin
        miscompares++;
        $display("FAIL b2b[%0d]: got g=%b rv=%b crd=%h drd=%h expected g=%b rv=%b crd=%h drd=%h",
                 k, {core_gnt, dma_gnt}, {core_rvalid, dma_rvalid}, core_rdata, dma_rdata,
                 gexp, rexp, exp_core_rdata, exp_dma_rdata);
      end
      advance();
    end
    idle_cycle();
  endtask

  task automatic test_store_with_rsp();
    logic [31:0] w8, want;
    w8   = init_val(8);
    want = {w8[31:16], 16'h5678};
    idle_cycle();
    dma_req = 1; dma_we = 0; dma_addr = 32'h20;
    settle();
    advance();
    idle_inputs();
    core_req = 1; core_we = 1; core_addr = 32'h30; core_wdata = 32'hCAFEF00D; core_be = 4'hF;
    settle();
    vectors++;
    if ({core_gnt, mem_we, mem_addr, dma_rvalid, dma_rdata, core_rvalid} !==
        {2'b11, 32'h30, 1'b1, want, 1'b0}) begin
      miscompares++;
      $display("FAIL store_with_rsp: got cg/we=%b addr=%h drv=%b drd=%h crv=%b expected 11 00000030 1 %h 0",
               {core_gnt, mem_we}, mem_addr, dma_rvalid, dma_rdata, core_rvalid, want);
    end
    advance();
    idle_cycle();
  endtask

  task automatic test_random();
    logic [138:0] obs, expv;
    idle_cycle();
    for (int n = 0; n < 400; n++) begin
      int granted;
      if (!core_req && $urandom_range(0, 2) != 0) begin
        core_req = 1; core_we = 1'($urandom_range(0, 1));
        core_addr = 32'($urandom_range(0, 255)); core_wdata = $urandom;
        core_be = 4'($urandom_range(1, 15));
      end
      if (!dma_req && $urandom_range(0, 2) != 0) begin
        dma_req = 1; dma_we = 1'($urandom_range(0, 1));
        dma_addr = 32'($urandom_range(0, 255)); dma_wdata = $urandom;
        dma_be = 4'($urandom_range(1, 15));
      end
      settle();
      obs  = {core_gnt, core_stall, dma_gnt, mem_en, mem_we, mem_addr, mem_wdata, mem_be,
              core_rvalid, core_rdata, dma_rvalid, dma_rdata};
      expv = {exp_core_gnt, exp_stall, exp_dma_gnt, exp_mem_en, exp_mem_we, exp_mem_addr,
              exp_mem_wdata, exp_mem_be, exp_core_rvalid, exp_core_rdata, exp_dma_rvalid,
              exp_dma_rdata};
      vectors++;
      if (obs !== expv) begin
        miscompares++;
        $display("FAIL random[%0d]: got %h expected %h", n, obs, expv);
      end
      granted = ref_win;
      advance();
      if (granted == 1) core_req = 0;
      if (granted == 2) dma_req = 0;
    end
    idle_cycle();
  endtask

  initial begin
    rst_n = 0;
    mem_init = 1;
    idle_inputs();
    for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
    ref_starve = 0; ref_rsp = 0; ref_win = 0; ref_rdata = '0;
    @(posedge clk);
    #1 mem_init = 0;
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    test_reset();
    test_core_load();
    test_dma_write();
    test_starvation();
    test_back_to_back();
    test_store_with_rsp();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
